// File: rtl/wb_scoreboard_arb_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard_arb_if
// Desc     : Issue, producer and writeback bundle for the writeback arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_scoreboard_arb_if;
    logic        iss_valid;
    logic        iss_rs_use;
    logic [3:0]  iss_rs_num;
    logic        iss_rt_use;
    logic [3:0]  iss_rt_num;
    logic        iss_rd_write;
    logic [3:0]  iss_rd_num;
    logic        iss_stall;
    logic        alu_valid;
    logic [3:0]  alu_rd_num;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        mem_valid;
    logic [3:0]  mem_rd_num;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        wb_rd_write_en;
    logic [3:0]  wb_rd_num;
    logic [31:0] wb_rd_in;
    logic [15:0] pending;
    logic        err_spurious;

    modport slave (
        input  iss_valid, iss_rs_use, iss_rs_num, iss_rt_use, iss_rt_num,
               iss_rd_write, iss_rd_num,
               alu_valid, alu_rd_num, alu_data,
               mem_valid, mem_rd_num, mem_data,
        output iss_stall, alu_ready, mem_ready,
               wb_rd_write_en, wb_rd_num, wb_rd_in, pending, err_spurious
    );

    modport master (
        output iss_valid, iss_rs_use, iss_rs_num, iss_rt_use, iss_rt_num,
               iss_rd_write, iss_rd_num,
               alu_valid, alu_rd_num, alu_data,
               mem_valid, mem_rd_num, mem_data,
        input  iss_stall, alu_ready, mem_ready,
               wb_rd_write_en, wb_rd_num, wb_rd_in, pending, err_spurious
    );
endinterface
`default_nettype wire

// File: rtl/wb_scoreboard_arb.sv
`default_nettype none
// ============================================================================
// Module   : wb_scoreboard_arb
// Desc     : Writeback arbiter (ALU vs load unit) and RAW/WAW hazard
//            scoreboard for the 16-entry register file.
// Options  : WBARB_FIXED_PRIO_EN - load unit always wins on contention
// Revision : 1.0 - initial release
// ============================================================================
module wb_scoreboard_arb #(
    parameter int MAX_OUTSTANDING = 8
) (
    input  wire logic          clk,
    input  wire logic          reset,
    wb_scoreboard_arb_if.slave bus
);
    localparam int               CNT_W     = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

`ifndef WBARB_FIXED_PRIO_EN
    typedef enum logic [0:0] {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_e;

    grant_e last_grant_q, last_grant_d;
`endif

    logic [15:0]      pending_q, pending_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_en_q, wb_en_d;
    logic [3:0]       wb_num_q, wb_num_d;
    logic [31:0]      wb_data_q, wb_data_d;
    logic             wb_spur_q, wb_spur_d;
    logic             err_q, err_d;

    logic        w_hazard;
    logic        w_stall;
    logic        w_accept;
    logic        w_gnt_alu;
    logic        w_gnt_mem;
    logic        w_gnt_any;
    logic [3:0]  w_gnt_num;
    logic [31:0] w_gnt_data;
    logic        w_gnt_pend;
    logic        w_retire;
    logic        w_dec;

    always_comb begin
        w_hazard = (bus.iss_rs_use   & pending_q[bus.iss_rs_num])
                 | (bus.iss_rt_use   & pending_q[bus.iss_rt_num])
                 | (bus.iss_rd_write & (pending_q[bus.iss_rd_num] | (cnt_q >= C_CNT_MAX)));
        w_stall  = ~reset | (bus.iss_valid & w_hazard);
        w_accept = bus.iss_valid & bus.iss_rd_write & ~w_stall;
    end

    always_comb begin
        w_gnt_alu = 1'b0;
        w_gnt_mem = 1'b0;
        if (reset) begin
            if (bus.alu_valid && bus.mem_valid) begin
`ifdef WBARB_FIXED_PRIO_EN
                w_gnt_mem = 1'b1;
`else
                if (last_grant_q == GRANT_MEM) w_gnt_alu = 1'b1;
                else                           w_gnt_mem = 1'b1;
`endif
            end else begin
                w_gnt_alu = bus.alu_valid;
                w_gnt_mem = bus.mem_valid;
            end
        end
    end

    always_comb begin
        w_gnt_any  = w_gnt_alu | w_gnt_mem;
        w_gnt_num  = w_gnt_mem ? bus.mem_rd_num : bus.alu_rd_num;
        w_gnt_data = w_gnt_mem ? bus.mem_data   : bus.alu_data;
        w_retire   = wb_en_q & ~wb_spur_q;
        w_dec      = w_retire & (cnt_q != '0);
        // A bit being cleared by this edge's retire is no longer a valid target.
        w_gnt_pend = pending_q[w_gnt_num] & ~(w_retire & (wb_num_q == w_gnt_num));

        pending_d = pending_q;
        if (w_retire) pending_d[wb_num_q]    = 1'b0;
        if (w_accept) pending_d[bus.iss_rd_num] = 1'b1;

        cnt_d = cnt_q;
        case ({w_accept, w_dec})
            2'b10:   cnt_d = cnt_q + C_CNT_ONE;
            2'b01:   cnt_d = cnt_q - C_CNT_ONE;
            default: cnt_d = cnt_q;
        endcase

        wb_en_d   = w_gnt_any;
        wb_num_d  = w_gnt_any ? w_gnt_num  : wb_num_q;
        wb_data_d = w_gnt_any ? w_gnt_data : wb_data_q;
        wb_spur_d = w_gnt_any & ~w_gnt_pend;
        err_d     = err_q | (wb_en_q & wb_spur_q);

`ifndef WBARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
        if (w_gnt_mem)      last_grant_d = GRANT_MEM;
        else if (w_gnt_alu) last_grant_d = GRANT_ALU;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pending_q    <= '0;
            cnt_q        <= '0;
            wb_en_q      <= 1'b0;
            wb_num_q     <= '0;
            wb_data_q    <= '0;
            wb_spur_q    <= 1'b0;
            err_q        <= 1'b0;
`ifndef WBARB_FIXED_PRIO_EN
            last_grant_q <= GRANT_MEM;
`endif
        end else begin
            pending_q    <= pending_d;
            cnt_q        <= cnt_d;
            wb_en_q      <= wb_en_d;
            wb_num_q     <= wb_num_d;
            wb_data_q    <= wb_data_d;
            wb_spur_q    <= wb_spur_d;
            err_q        <= err_d;
`ifndef WBARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign bus.iss_stall      = w_stall;
    assign bus.alu_ready      = w_gnt_alu;
    assign bus.mem_ready      = w_gnt_mem;
    assign bus.wb_rd_write_en = wb_en_q;
    assign bus.wb_rd_num      = wb_num_q;
    assign bus.wb_rd_in       = wb_data_q;
    assign bus.pending        = pending_q;
    assign bus.err_spurious   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_scoreboard_arb
// Desc     : Directed and randomized checks of wb_scoreboard_arb against an
//            in-flight-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_scoreboard_arb;
    localparam int MAXO = 8;

    logic clk = 1'b0;
    logic reset;

    wb_scoreboard_arb_if bus ();

    wb_scoreboard_arb #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: destinations issued but not yet retired, in a queue.
    int          m_q[$];
    bit          m_last_mem = 1'b1;
    bit          m_wb_en    = 1'b0;
    logic [3:0]  m_wb_num   = '0;
    logic [31:0] m_wb_data  = '0;
    bit          m_wb_spur  = 1'b0;
    bit          m_err      = 1'b0;
    bit          m_valid    = 1'b0;

    function automatic bit m_has(int r);
        foreach (m_q[i]) if (m_q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] m_pend();
        logic [15:0] p;
        p = '0;
        foreach (m_q[i]) p[m_q[i]] = 1'b1;
        return p;
    endfunction

    always @(negedge clk) begin
        bit e_stall;
        bit g_alu;
        bit g_mem;
        int idx;
        if (!reset) begin
            if (m_valid) begin
                check("cmp_rst_stall", bus.iss_stall, 1);
                check("cmp_rst_alu_ready", bus.alu_ready, 0);
                check("cmp_rst_mem_ready", bus.mem_ready, 0);
            end
            m_q.delete();
            m_last_mem = 1'b1;
            m_wb_en    = 1'b0;
            m_wb_num   = '0;
            m_wb_data  = '0;
            m_wb_spur  = 1'b0;
            m_err      = 1'b0;
            m_valid    = 1'b1;
        end else if (m_valid) begin
            e_stall = bus.iss_valid && (
                      (bus.iss_rs_use && m_has(bus.iss_rs_num)) ||
                      (bus.iss_rt_use && m_has(bus.iss_rt_num)) ||
                      (bus.iss_rd_write && (m_has(bus.iss_rd_num) || m_q.size() >= MAXO)));
            g_alu = 1'b0;
            g_mem = 1'b0;
            if (bus.alu_valid && bus.mem_valid) begin
`ifdef WBARB_FIXED_PRIO_EN
                g_mem = 1'b1;
`else
                if (m_last_mem) g_alu = 1'b1;
                else            g_mem = 1'b1;
`endif
            end else begin
                g_alu = bus.alu_valid;
                g_mem = bus.mem_valid;
            end

            check("cmp_stall", bus.iss_stall, e_stall);
            check("cmp_alu_ready", bus.alu_ready, g_alu);
            check("cmp_mem_ready", bus.mem_ready, g_mem);
            check("cmp_wb_en", bus.wb_rd_write_en, m_wb_en);
            check("cmp_wb_num", bus.wb_rd_num, m_wb_num);
            check("cmp_wb_data", bus.wb_rd_in, m_wb_data);
            check("cmp_pending", bus.pending, m_pend());
            check("cmp_err", bus.err_spurious, m_err);

            if (m_wb_en) begin
                if (m_wb_spur) begin
                    m_err = 1'b1;
                end else begin
                    idx = -1;
                    foreach (m_q[i]) if (m_q[i] == m_wb_num) idx = i;
                    if (idx >= 0) m_q.delete(idx);
                end
            end
            m_wb_en = g_alu || g_mem;
            if (m_wb_en) begin
                m_wb_num   = g_mem ? bus.mem_rd_num : bus.alu_rd_num;
                m_wb_data  = g_mem ? bus.mem_data   : bus.alu_data;
                m_wb_spur  = !m_has(m_wb_num);
                m_last_mem = g_mem;
            end
            if (bus.iss_valid && !e_stall && bus.iss_rd_write) m_q.push_back(int'(bus.iss_rd_num));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iss_valid    = 0; bus.iss_rs_use = 0; bus.iss_rs_num = 0;
        bus.iss_rt_use   = 0; bus.iss_rt_num = 0;
        bus.iss_rd_write = 0; bus.iss_rd_num = 0;
        bus.alu_valid    = 0; bus.alu_rd_num = 0; bus.alu_data = 0;
        bus.mem_valid    = 0; bus.mem_rd_num = 0; bus.mem_data = 0;
    endtask

    task automatic do_reset(input int n);
        reset = 0;
        repeat (n) tick();
        reset = 1;
    endtask

    task automatic issue(input int rd);
        bus.iss_valid    = 1;
        bus.iss_rd_write = 1;
        bus.iss_rd_num   = 4'(rd);
    endtask

    // Pick a pending register not already claimed by the other producer or the wb stage.
    function automatic int pick_reg(input int excl);
        int c[$];
        for (int r = 0; r < 16; r++)
            if (m_has(r) && r != excl && !(m_wb_en && m_wb_num == 4'(r))) c.push_back(r);
        if (c.size() == 0) return -1;
        return c[$urandom_range(0, c.size() - 1)];
    endfunction

    initial begin
        bit a_rdy;
        bit m_rdy;
        int r;

        reset = 0;
        idle_inputs();

        // Reset with both producers requesting
        bus.alu_valid = 1; bus.alu_rd_num = 4'd6; bus.alu_data = 32'h1111_0000;
        bus.mem_valid = 1; bus.mem_rd_num = 4'd7; bus.mem_data = 32'h2222_0000;
        repeat (2) begin
            tick(); #1;
            check("rst_alu_ready", bus.alu_ready, 0);
            check("rst_mem_ready", bus.mem_ready, 0);
            check("rst_pending", bus.pending, 0);
            check("rst_wb_en", bus.wb_rd_write_en, 0);
            check("rst_stall", bus.iss_stall, 1);
        end
        reset = 1; #1;
`ifdef WBARB_FIXED_PRIO_EN
        check("first_grant_mem", bus.mem_ready, 1);
        check("first_grant_alu", bus.alu_ready, 0);
        tick(); bus.mem_valid = 0; #1;
        check("second_grant_alu", bus.alu_ready, 1);
        tick(); bus.alu_valid = 0;
`else
        check("first_grant_alu", bus.alu_ready, 1);
        check("first_grant_mem", bus.mem_ready, 0);
        tick(); bus.alu_valid = 0; #1;
        check("second_grant_mem", bus.mem_ready, 1);
        check("first_wb_num", bus.wb_rd_num, 6);
        tick(); bus.mem_valid = 0; #1;
        check("second_wb_num", bus.wb_rd_num, 7);
        check("second_wb_data", bus.wb_rd_in, 32'h2222_0000);
`endif
        do_reset(1);

        // RAW hazard on r3
        issue(3); #1;
        check("raw_issue_stall", bus.iss_stall, 0);
        tick(); bus.iss_rd_write = 0; bus.iss_rs_use = 1; bus.iss_rs_num = 4'd3; #1;
        check("raw_stall", bus.iss_stall, 1);
        check("raw_pending", bus.pending, 16'h0008);
        tick(); bus.alu_valid = 1; bus.alu_rd_num = 4'd3; bus.alu_data = 32'hDEAD_BEEF; #1;
        check("raw_alu_ready", bus.alu_ready, 1);
        check("raw_stall_hold", bus.iss_stall, 1);
        tick(); bus.alu_valid = 0; #1;
        check("raw_wb_en", bus.wb_rd_write_en, 1);
        check("raw_wb_num", bus.wb_rd_num, 3);
        check("raw_wb_data", bus.wb_rd_in, 32'hDEAD_BEEF);
        check("raw_stall_strobe", bus.iss_stall, 1);
        tick(); #1;
        check("raw_wb_done", bus.wb_rd_write_en, 0);
        check("raw_unstall", bus.iss_stall, 0);
        check("raw_pending_clr", bus.pending, 0);
        idle_inputs();
        do_reset(1);

        // Contention between ALU (r1) and MEM (r2)
        issue(1); tick(); issue(2); tick(); bus.iss_valid = 0;
        bus.alu_valid = 1; bus.alu_rd_num = 4'd1; bus.alu_data = 32'hA1;
        bus.mem_valid = 1; bus.mem_rd_num = 4'd2; bus.mem_data = 32'hB2; #1;
`ifdef WBARB_FIXED_PRIO_EN
        check("cont_first_mem", bus.mem_ready, 1);
        check("cont_first_alu", bus.alu_ready, 0);
        tick(); bus.mem_valid = 0; #1;
        check("cont_second_alu", bus.alu_ready, 1);
        check("cont_wb_num0", bus.wb_rd_num, 2);
        tick(); bus.alu_valid = 0; #1;
        check("cont_wb_en1", bus.wb_rd_write_en, 1);
        check("cont_wb_num1", bus.wb_rd_num, 1);
`else
        check("cont_first_alu", bus.alu_ready, 1);
        check("cont_first_mem", bus.mem_ready, 0);
        tick(); bus.alu_valid = 0; #1;
        check("cont_second_mem", bus.mem_ready, 1);
        check("cont_wb_num0", bus.wb_rd_num, 1);
        tick(); bus.mem_valid = 0; #1;
        check("cont_wb_en1", bus.wb_rd_write_en, 1);
        check("cont_wb_num1", bus.wb_rd_num, 2);
`endif
        tick(); #1;
        check("cont_pending", bus.pending, 0);
        idle_inputs();
        do_reset(1);

        // Outstanding limit
        for (int i = 0; i < MAXO; i++) begin
            issue(i); #1;
            check("lim_accept", bus.iss_stall, 0);
            tick();
        end
        issue(8);
        bus.alu_valid = 1; bus.alu_rd_num = 4'd0; bus.alu_data = 32'h0C0C_0C0C; #1;
        check("lim_9th_stall", bus.iss_stall, 1);
        check("lim_alu_ready", bus.alu_ready, 1);
        tick(); bus.alu_valid = 0; #1;
        check("lim_stall_strobe", bus.iss_stall, 1);
        tick(); #1;
        check("lim_unstall", bus.iss_stall, 0);
        tick(); bus.iss_valid = 0; #1;
        check("lim_pending", bus.pending, 16'h01FE);
        check("model_pend_lim", m_pend(), 16'h01FE);
        idle_inputs();
        do_reset(1);

        // Issue r5 on the edge that retires r4
        issue(4); tick(); bus.iss_valid = 0;
        bus.alu_valid = 1; bus.alu_rd_num = 4'd4; bus.alu_data = 32'h44; #1;
        check("sim_alu_ready", bus.alu_ready, 1);
        tick(); bus.alu_valid = 0; issue(5); #1;
        check("sim_wb_num", bus.wb_rd_num, 4);
        check("sim_stall", bus.iss_stall, 0);
        tick(); bus.iss_valid = 0; #1;
        check("sim_pending", bus.pending, 16'h0020);
        check("model_pend_sim", m_pend(), 16'h0020);

        // Spurious write to r9
        bus.mem_valid = 1; bus.mem_rd_num = 4'd9; bus.mem_data = 32'h99; #1;
        check("spur_mem_ready", bus.mem_ready, 1);
        tick(); bus.mem_valid = 0; #1;
        check("spur_wb_en", bus.wb_rd_write_en, 1);
        check("spur_wb_num", bus.wb_rd_num, 9);
        check("spur_wb_data", bus.wb_rd_in, 32'h99);
        tick(); #1;
        check("spur_err", bus.err_spurious, 1);
        check("spur_pending", bus.pending, 16'h0020);

        // Count after set/retire must be 1: seven more fit, the eighth stalls
        for (int i = 6; i < 13; i++) begin
            issue(i); #1;
            check("cnt_accept", bus.iss_stall, 0);
            tick();
        end
        issue(13); #1;
        check("cnt_full_stall", bus.iss_stall, 1);
        bus.iss_valid = 0;
        check("spur_err_sticky", bus.err_spurious, 1);
        do_reset(1); #1;
        check("err_cleared", bus.err_spurious, 0);
        check("pend_cleared", bus.pending, 0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset = 0; bus.alu_valid = 0; bus.mem_valid = 0;
            end else begin
                reset = 1;
            end
            if (reset && !bus.alu_valid && $urandom_range(0, 2) == 0) begin
                r = pick_reg(bus.mem_valid ? int'(bus.mem_rd_num) : -1);
                if (r >= 0) begin
                    bus.alu_valid = 1; bus.alu_rd_num = 4'(r); bus.alu_data = $urandom;
                end
            end
            if (reset && !bus.mem_valid && $urandom_range(0, 2) == 0) begin
                r = pick_reg(bus.alu_valid ? int'(bus.alu_rd_num) : -1);
                if (r >= 0) begin
                    bus.mem_valid = 1; bus.mem_rd_num = 4'(r); bus.mem_data = $urandom;
                end
            end
            bus.iss_valid    = 1'($urandom_range(0, 1));
            bus.iss_rs_use   = 1'($urandom_range(0, 1));
            bus.iss_rs_num   = 4'($urandom_range(0, 15));
            bus.iss_rt_use   = 1'($urandom_range(0, 1));
            bus.iss_rt_num   = 4'($urandom_range(0, 15));
            bus.iss_rd_write = ($urandom_range(0, 3) != 0);
            bus.iss_rd_num   = 4'($urandom_range(0, 15));
            #2;
            a_rdy = bus.alu_ready;
            m_rdy = bus.mem_ready;
            tick();
            if (a_rdy) bus.alu_valid = 0;
            if (m_rdy) bus.mem_valid = 0;
        end

        reset = 1;
        idle_inputs();
        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
